// File: rtl/lsu_arb_if.sv
// Bus bundle for the LSU arbiter: requester channels, shared response,
// SRAM target port and AXI master port.
// The slave modport is the arbiter's view; the master modport is the
// surrounding system's view (requesters plus both targets).
interface lsu_arb_if #(
  parameter int NCH = 3
);
  logic [NCH-1:0]     req_val;
  logic [NCH-1:0]     req_rdy;
  logic [32*NCH-1:0]  req_adr;
  logic [32*NCH-1:0]  req_wdat;
  logic [4*NCH-1:0]   req_wen;
  logic [NCH-1:0]     req_ren;
  logic [31:0]        rsp_rdat;
  logic               rsp_err;
  logic               sram_val;
  logic               sram_ren;
  logic [3:0]         sram_wen;
  logic [31:0]        sram_rdat;
  logic               axim_val;
  logic               axim_ren;
  logic [3:0]         axim_wen;
  logic               axim_rdy;
  logic [31:0]        axim_rdat;
  logic [31:0]        adr;
  logic [31:0]        wdat;

  modport slave (
    input  req_val, req_adr, req_wdat, req_wen, req_ren,
    input  sram_rdat, axim_rdy, axim_rdat,
    output req_rdy, rsp_rdat, rsp_err,
    output sram_val, sram_ren, sram_wen,
    output axim_val, axim_ren, axim_wen,
    output adr, wdat
  );

  modport master (
    output req_val, req_adr, req_wdat, req_wen, req_ren,
    output sram_rdat, axim_rdy, axim_rdat,
    input  req_rdy, rsp_rdat, rsp_err,
    input  sram_val, sram_ren, sram_wen,
    input  axim_val, axim_ren, axim_wen,
    input  adr, wdat
  );
endinterface

// File: rtl/lsu_arb.sv
// LSU arbiter: picks one of NCH requesters (fixed priority or round-robin),
// routes it to SRAM (fixed one-cycle read latency) or to an AXI master port
// (variable latency with optional timeout), and returns a one-cycle
// completion pulse to the granted channel.
module lsu_arb #(
  parameter int          NCH     = 3,
  parameter int          RR      = 0,
  parameter logic [15:0] SRAM_HI = 16'h8000,
  parameter int          TMO     = 255
) (
  input logic      clk,
  input logic      rst_n,
  lsu_arb_if.slave bus
);

  localparam int          GW       = $clog2(NCH);
  localparam logic [GW-1:0] LAST_CH = GW'(NCH - 1);
  localparam bit          TMO_EN   = (TMO != 0);
  localparam logic [15:0] TMO_LAST = (TMO == 0) ? 16'hFFFF : 16'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SRAM_RSP = 2'd1,
    AXI_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [31:0]     cmdAdr_q, cmdAdr_d;
  logic [31:0]     cmdWdat_q, cmdWdat_d;
  logic [3:0]      cmdWen_q, cmdWen_d;
  logic            cmdRen_q, cmdRen_d;
  logic [15:0]     tmoCnt_q, tmoCnt_d;

  logic [31:0]     chAdr  [NCH];
  logic [31:0]     chWdat [NCH];
  logic [3:0]      chWen  [NCH];
  logic            chRen  [NCH];

  logic            anyReq;
  logic [GW-1:0]   pick;
  logic            pickSram;
  logic            timeout;

  logic [NCH-1:0]  reqRdy;
  logic [31:0]     rspRdat;
  logic            rspErr;
  logic            sramVal, sramRen;
  logic [3:0]      sramWen;
  logic            axiVal, axiRen;
  logic [3:0]      axiWen;
  logic [31:0]     adrOut, wdatOut;

  // Flattened channel buses viewed as per-channel arrays
  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign chAdr[i]  = bus.req_adr[32*i +: 32];
    assign chWdat[i] = bus.req_wdat[32*i +: 32];
    assign chWen[i]  = bus.req_wen[4*i +: 4];
    assign chRen[i]  = bus.req_ren[i];
  end

  // Arbitration: lowest index wins, or first requester above the last winner
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    pick   = '0;
    anyReq = |bus.req_val;
    if (RR == 0) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (bus.req_val[i]) begin
          pick = GW'(i);
        end
      end
    end else begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (int'(ptr_q) + k) % NCH;
        if (!found && bus.req_val[idx]) begin
          pick  = GW'(idx);
          found = 1'b1;
        end
      end
    end
  end

  assign pickSram = (chAdr[pick][31:16] == SRAM_HI);
  assign timeout  = TMO_EN && (tmoCnt_q == TMO_LAST);

  // Next-state and target/response drive; the grant cycle steers the chosen
  // channel straight through, AXI_WAIT replays the captured command
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cmdAdr_d  = cmdAdr_q;
    cmdWdat_d = cmdWdat_q;
    cmdWen_d  = cmdWen_q;
    cmdRen_d  = cmdRen_q;
    tmoCnt_d  = tmoCnt_q;
    reqRdy    = '0;
    rspRdat   = '0;
    rspErr    = 1'b0;
    sramVal   = 1'b0;
    sramRen   = 1'b0;
    sramWen   = '0;
    axiVal    = 1'b0;
    axiRen    = 1'b0;
    axiWen    = '0;
    adrOut    = '0;
    wdatOut   = '0;
    unique case (state_q)
      IDLE: begin
        if (anyReq) begin
          grant_d   = pick;
          cmdAdr_d  = chAdr[pick];
          cmdWdat_d = chWdat[pick];
          cmdWen_d  = chWen[pick];
          cmdRen_d  = chRen[pick];
          if (RR != 0) begin
            ptr_d = pick;
          end
          adrOut  = chAdr[pick];
          wdatOut = chWdat[pick];
          if (pickSram) begin
            sramVal = 1'b1;
            sramWen = chWen[pick];
            sramRen = chRen[pick];
            state_d = SRAM_RSP;
          end else begin
            axiVal   = 1'b1;
            axiWen   = chWen[pick];
            axiRen   = chRen[pick];
            tmoCnt_d = '0;
            state_d  = AXI_WAIT;
          end
        end
      end
      SRAM_RSP: begin
        reqRdy[grant_q] = 1'b1;
        rspRdat         = bus.sram_rdat;
        state_d         = IDLE;
      end
      AXI_WAIT: begin
        axiVal  = 1'b1;
        axiWen  = cmdWen_q;
        axiRen  = cmdRen_q;
        adrOut  = cmdAdr_q;
        wdatOut = cmdWdat_q;
        if (bus.axim_rdy) begin
          reqRdy[grant_q] = 1'b1;
          rspRdat         = bus.axim_rdat;
          state_d         = IDLE;
        end else if (timeout) begin
          reqRdy[grant_q] = 1'b1;
          rspErr          = 1'b1;
          state_d         = IDLE;
        end else begin
          tmoCnt_d = tmoCnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured command; reset parks the pointer so channel 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= LAST_CH;
      cmdAdr_q  <= '0;
      cmdWdat_q <= '0;
      cmdWen_q  <= '0;
      cmdRen_q  <= 1'b0;
      tmoCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cmdAdr_q  <= cmdAdr_d;
      cmdWdat_q <= cmdWdat_d;
      cmdWen_q  <= cmdWen_d;
      cmdRen_q  <= cmdRen_d;
      tmoCnt_q  <= tmoCnt_d;
    end
  end

  // Outputs are combinational, so reset gates them directly to take effect at once
  assign bus.req_rdy  = rst_n ? reqRdy  : '0;
  assign bus.rsp_rdat = rst_n ? rspRdat : '0;
  assign bus.rsp_err  = rst_n ? rspErr  : 1'b0;
  assign bus.sram_val = rst_n ? sramVal : 1'b0;
  assign bus.sram_ren = rst_n ? sramRen : 1'b0;
  assign bus.sram_wen = rst_n ? sramWen : '0;
  assign bus.axim_val = rst_n ? axiVal  : 1'b0;
  assign bus.axim_ren = rst_n ? axiRen  : 1'b0;
  assign bus.axim_wen = rst_n ? axiWen  : '0;
  assign bus.adr      = rst_n ? adrOut  : '0;
  assign bus.wdat     = rst_n ? wdatOut : '0;

endmodule

// File: tb/tb_lsu_arb.sv
// Directed bench for lsu_arb: a fixed-priority instance (default timeout)
// and a round-robin instance with a short AXI timeout share clock and reset.
module tb_lsu_arb;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   axHigh;

  lsu_arb_if #(.NCH(3)) b0 ();
  lsu_arb_if #(.NCH(3)) b1 ();

  lsu_arb #(.NCH(3), .RR(0), .SRAM_HI(16'h8000), .TMO(255)) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b0.slave)
  );

  lsu_arb #(.NCH(3), .RR(1), .SRAM_HI(16'h8000), .TMO(4)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1.slave)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int which, input int ch, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] we, input logic re);
    if (which == 0) begin
      b0.req_adr[32*ch +: 32] = a;
      b0.req_wdat[32*ch +: 32] = wd;
      b0.req_wen[4*ch +: 4] = we;
      b0.req_ren[ch] = re;
    end else begin
      b1.req_adr[32*ch +: 32] = a;
      b1.req_wdat[32*ch +: 32] = wd;
      b1.req_wen[4*ch +: 4] = we;
      b1.req_ren[ch] = re;
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; inputs change 1 after the edge, outputs sampled 2 after
  initial begin
    errors = 0;
    checks = 0;
    axHigh = 0;
    rst_n = 1'b0;
    b0.req_val = '0; b0.req_adr = '0; b0.req_wdat = '0; b0.req_wen = '0; b0.req_ren = '0;
    b0.sram_rdat = '0; b0.axim_rdy = 1'b0; b0.axim_rdat = '0;
    b1.req_val = '0; b1.req_adr = '0; b1.req_wdat = '0; b1.req_wen = '0; b1.req_ren = '0;
    b1.sram_rdat = '0; b1.axim_rdy = 1'b0; b1.axim_rdat = '0;
    applyStimulus(0, 0, 32'h8000_0000, 32'h1111_1111, 4'hF, 1'b1);
    b0.req_val = 3'b001;
    #2;
    checkOutput("rst_sram_val", 32'(b0.sram_val), 32'h0);
    checkOutput("rst_sram_wen", 32'(b0.sram_wen), 32'h0);
    checkOutput("rst_req_rdy", 32'(b0.req_rdy), 32'h0);
    checkOutput("rst_adr", b0.adr, 32'h0);
    checkOutput("rst_wdat", b0.wdat, 32'h0);
    checkOutput("rst_axim_val", 32'(b0.axim_val), 32'h0);
    checkOutput("rst_rsp", {b0.rsp_rdat[30:0], b0.rsp_err}, 32'h0);
    checkOutput("rst1_req_rdy", 32'(b1.req_rdy), 32'h0);

    // Fixed priority: ch1 beats ch2, then ch2 served
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 1'b0);
    applyStimulus(0, 1, 32'h8000_0010, 32'h0, 4'h0, 1'b1);
    applyStimulus(0, 2, 32'h8000_0020, 32'h0, 4'h0, 1'b1);
    b0.req_val = 3'b110;
    b0.sram_rdat = 32'hDEAD_BEEF;
    nextCycle();
    rst_n = 1'b1;
    #1;
    checkOutput("fp_grant_sram_val", 32'(b0.sram_val), 32'h1);
    checkOutput("fp_grant_sram_ren", 32'(b0.sram_ren), 32'h1);
    checkOutput("fp_grant_adr", b0.adr, 32'h8000_0010);
    checkOutput("fp_grant_no_rdy", 32'(b0.req_rdy), 32'h0);
    checkOutput("fp_grant_axim_val", 32'(b0.axim_val), 32'h0);
    nextCycle();
    b0.req_val = 3'b100;
    #1;
    checkOutput("fp_rsp_rdy", 32'(b0.req_rdy), 32'h2);
    checkOutput("fp_rsp_rdat", b0.rsp_rdat, 32'hDEAD_BEEF);
    checkOutput("fp_rsp_err", 32'(b0.rsp_err), 32'h0);
    checkOutput("fp_rsp_sram_val", 32'(b0.sram_val), 32'h0);
    checkOutput("fp_rsp_adr", b0.adr, 32'h0);
    nextCycle();
    #1;
    checkOutput("fp_ch2_sram_val", 32'(b0.sram_val), 32'h1);
    checkOutput("fp_ch2_adr", b0.adr, 32'h8000_0020);
    nextCycle();
    b0.req_val = 3'b000;
    #1;
    checkOutput("fp_ch2_rdy", 32'(b0.req_rdy), 32'h4);
    nextCycle();
    #1;
    checkOutput("fp_idle_sram_val", 32'(b0.sram_val), 32'h0);
    checkOutput("fp_idle_rdy", 32'(b0.req_rdy), 32'h0);

    // Empty command (no byte or read enables) still completes
    nextCycle();
    applyStimulus(0, 2, 32'h8000_0040, 32'h0, 4'h0, 1'b0);
    b0.req_val = 3'b100;
    #1;
    checkOutput("nop_sram_val", 32'(b0.sram_val), 32'h1);
    checkOutput("nop_sram_en", {27'd0, b0.sram_ren, b0.sram_wen}, 32'h0);
    checkOutput("nop_adr", b0.adr, 32'h8000_0040);
    nextCycle();
    b0.req_val = 3'b000;
    #1;
    checkOutput("nop_rdy", 32'(b0.req_rdy), 32'h4);

    // AXI write, rdy in the grant cycle must be ignored, completes in wait cycle 5
    nextCycle();
    applyStimulus(0, 0, 32'h4000_0000, 32'h1234_5678, 4'hF, 1'b0);
    b0.req_val = 3'b001;
    b0.axim_rdy = 1'b1;
    #1;
    checkOutput("axw_grant_axim_val", 32'(b0.axim_val), 32'h1);
    checkOutput("axw_grant_adr", b0.adr, 32'h4000_0000);
    checkOutput("axw_grant_wdat", b0.wdat, 32'h1234_5678);
    checkOutput("axw_grant_axim_wen", 32'(b0.axim_wen), 32'hF);
    checkOutput("axw_grant_sram", {27'd0, b0.sram_val, b0.sram_wen}, 32'h0);
    checkOutput("axw_grant_no_rdy", 32'(b0.req_rdy), 32'h0);
    if (b0.axim_val) axHigh++;
    for (int w = 1; w <= 4; w++) begin
      nextCycle();
      b0.axim_rdy = 1'b0;
      b0.req_val = 3'b000;
      applyStimulus(0, 0, 32'h8000_0000, 32'h0, 4'h0, 1'b1);
      #1;
      if (b0.axim_val) axHigh++;
      checkOutput("axw_wait_adr", b0.adr, 32'h4000_0000);
      checkOutput("axw_wait_wdat", b0.wdat, 32'h1234_5678);
      checkOutput("axw_wait_wen", 32'(b0.axim_wen), 32'hF);
      checkOutput("axw_wait_no_rdy", 32'(b0.req_rdy), 32'h0);
    end
    nextCycle();
    b0.axim_rdy = 1'b1;
    b0.axim_rdat = 32'hCAFE_F00D;
    #1;
    if (b0.axim_val) axHigh++;
    checkOutput("axw_done_rdy", 32'(b0.req_rdy), 32'h1);
    checkOutput("axw_done_err", 32'(b0.rsp_err), 32'h0);
    checkOutput("axw_done_rdat", b0.rsp_rdat, 32'hCAFE_F00D);
    nextCycle();
    b0.axim_rdy = 1'b0;
    #1;
    checkOutput("axw_after_axim_val", 32'(b0.axim_val), 32'h0);
    checkOutput("axw_after_rdy", 32'(b0.req_rdy), 32'h0);
    checkOutput("axw_after_adr", b0.adr, 32'h0);
    checkOutput("axw_high_cycles", 32'(axHigh), 32'd6);

    // Reset during AXI_WAIT aborts silently; pending ch0 regranted after release
    nextCycle();
    applyStimulus(0, 0, 32'h0000_1000, 32'h0, 4'h0, 1'b1);
    b0.req_val = 3'b001;
    #1;
    checkOutput("rsw_grant_axim_ren", 32'(b0.axim_ren), 32'h1);
    nextCycle();
    #1;
    checkOutput("rsw_wait1_axim_val", 32'(b0.axim_val), 32'h1);
    nextCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("rsw_rst_axim_val", 32'(b0.axim_val), 32'h0);
    checkOutput("rsw_rst_axim_ren", 32'(b0.axim_ren), 32'h0);
    checkOutput("rsw_rst_rdy", 32'(b0.req_rdy), 32'h0);
    checkOutput("rsw_rst_adr", b0.adr, 32'h0);
    nextCycle();
    checkOutput("rsw_rst_edge_rdy", 32'(b0.req_rdy), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rsw_regrant_axim_val", 32'(b0.axim_val), 32'h1);
    checkOutput("rsw_regrant_adr", b0.adr, 32'h0000_1000);
    checkOutput("rsw_regrant_no_rdy", 32'(b0.req_rdy), 32'h0);
    nextCycle();
    b0.axim_rdy = 1'b1;
    b0.axim_rdat = 32'h55AA_55AA;
    #1;
    checkOutput("rsw_wait_ren", 32'(b0.axim_ren), 32'h1);
    checkOutput("rsw_done_rdy", 32'(b0.req_rdy), 32'h1);
    checkOutput("rsw_done_rdat", b0.rsp_rdat, 32'h55AA_55AA);
    nextCycle();
    b0.axim_rdy = 1'b0;
    b0.req_val = 3'b000;
    #1;
    checkOutput("rsw_idle_axim_val", 32'(b0.axim_val), 32'h0);

    // Round-robin over three continuously valid SRAM requesters
    nextCycle();
    applyStimulus(1, 0, 32'h8000_0000, 32'h0, 4'h0, 1'b1);
    applyStimulus(1, 1, 32'h8000_0004, 32'h0, 4'h0, 1'b1);
    applyStimulus(1, 2, 32'h8000_0008, 32'h0, 4'h0, 1'b1);
    b1.req_val = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      checkOutput("rr_grant_sram_val", 32'(b1.sram_val), 32'h1);
      checkOutput("rr_grant_adr", b1.adr, 32'h8000_0000 + 32'(4 * (k % 3)));
      nextCycle();
      b1.sram_rdat = 32'hA000_0000 + 32'(k);
      if (k == 5) b1.req_val = 3'b000;
      #1;
      checkOutput("rr_rsp_rdy", 32'(b1.req_rdy), 32'(1 << (k % 3)));
      checkOutput("rr_rsp_rdat", b1.rsp_rdat, 32'hA000_0000 + 32'(k));
      checkOutput("rr_rsp_sram_val", 32'(b1.sram_val), 32'h0);
      nextCycle();
    end

    // Timeout (TMO=4): error completion in the fourth AXI_WAIT cycle
    applyStimulus(1, 0, 32'h4000_0000, 32'h0, 4'h0, 1'b1);
    b1.req_val = 3'b001;
    b1.axim_rdat = 32'hFFFF_FFFF;
    #1;
    checkOutput("tmo_grant_axim_val", 32'(b1.axim_val), 32'h1);
    checkOutput("tmo_grant_axim_ren", 32'(b1.axim_ren), 32'h1);
    for (int w = 1; w <= 3; w++) begin
      nextCycle();
      #1;
      checkOutput("tmo_wait_no_rdy", 32'(b1.req_rdy), 32'h0);
      checkOutput("tmo_wait_axim_val", 32'(b1.axim_val), 32'h1);
    end
    nextCycle();
    #1;
    checkOutput("tmo_fire_rdy", 32'(b1.req_rdy), 32'h1);
    checkOutput("tmo_fire_err", 32'(b1.rsp_err), 32'h1);
    checkOutput("tmo_fire_rdat", b1.rsp_rdat, 32'h0);
    nextCycle();
    b1.req_val = 3'b000;
    #1;
    checkOutput("tmo_idle_axim_val", 32'(b1.axim_val), 32'h0);
    checkOutput("tmo_idle_rdy", 32'(b1.req_rdy), 32'h0);
    checkOutput("tmo_idle_err", 32'(b1.rsp_err), 32'h0);

    // axim_rdy coinciding with the timeout cycle wins
    nextCycle();
    b1.req_val = 3'b001;
    b1.axim_rdat = 32'h0BAD_F00D;
    #1;
    checkOutput("tie_grant_axim_val", 32'(b1.axim_val), 32'h1);
    for (int w = 1; w <= 3; w++) begin
      nextCycle();
      #1;
      checkOutput("tie_wait_no_rdy", 32'(b1.req_rdy), 32'h0);
    end
    nextCycle();
    b1.axim_rdy = 1'b1;
    #1;
    checkOutput("tie_rdy", 32'(b1.req_rdy), 32'h1);
    checkOutput("tie_err", 32'(b1.rsp_err), 32'h0);
    checkOutput("tie_rdat", b1.rsp_rdat, 32'h0BAD_F00D);
    nextCycle();
    b1.axim_rdy = 1'b0;
    b1.req_val = 3'b000;
    #1;
    checkOutput("tie_idle_axim_val", 32'(b1.axim_val), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
